// File: rtl/ctrl_sequencer_if.sv
// ctrl_sequencer_if: control-strobe bundle between the hardwired sequencer
// and the datapath. The sequencer takes the master modport, and the datapath
// takes the slave modport.
// Optional: CTRL_STEP_EN adds the single-step input 'step'.
interface ctrl_sequencer_if;
    logic [31:0] IR;
    logic        stop;
`ifdef CTRL_STEP_EN
    logic        step;
`endif
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic        PCin;
    logic        PCout;
    logic        IncPC;
    logic        MARin;
    logic        MDRin;
    logic        MDRout;
    logic        Read;
    logic        IRin;
    logic        Yin;
    logic        Zlowin;
    logic        Zlowout;
    logic [3:0]  ALUop;
    logic        run;

    modport master (
`ifdef CTRL_STEP_EN
        input  step,
`endif
        input  IR, stop,
        output Rin, Rout, PCin, PCout, IncPC, MARin, MDRin, MDRout, Read,
               IRin, Yin, Zlowin, Zlowout, ALUop, run
    );

    modport slave (
`ifdef CTRL_STEP_EN
        output step,
`endif
        output IR, stop,
        input  Rin, Rout, PCin, PCout, IncPC, MARin, MDRin, MDRout, Read,
               IRin, Yin, Zlowin, Zlowout, ALUop, run
    );
endinterface

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: hardwired T-state control unit. It fetches an instruction
// and then executes register-register ALU operations. Strobes are decoded
// combinationally from the state register and the IR fields, because IR is
// only valid from T3 onward.
// Optional: CTRL_STEP_EN adds a WAIT state that is gated by bus.step ahead of
// every T0.
module ctrl_sequencer #(
    parameter logic [3:0] ALU_ADD = 4'd0,
    parameter logic [3:0] ALU_SUB = 4'd1,
    parameter logic [3:0] ALU_NOT = 4'd2,
    parameter logic [3:0] ALU_AND = 4'd3,
    parameter logic [3:0] ALU_OR  = 4'd4,
    parameter logic [3:0] ALU_NEG = 4'd5
) (
    input  logic              clock,
    input  logic              clear,
    ctrl_sequencer_if.master  bus
);

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        ST_RST,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_HALT
`ifdef CTRL_STEP_EN
        , ST_WAIT
`endif
    } state_t;

    state_t      r_state;
    state_t      w_fetch_next;
    logic [4:0]  w_opcode;
    logic [3:0]  w_ra;
    logic [3:0]  w_rb;
    logic [3:0]  w_rc;
    logic [15:0] w_ra_hot;
    logic [15:0] w_rb_hot;
    logic [15:0] w_rc_hot;
    logic        w_binary;
    logic        w_unary;
    logic        w_halt;
    logic [3:0]  w_alu_code;

    assign w_opcode = bus.IR[31:27];
    assign w_ra     = bus.IR[26:23];
    assign w_rb     = bus.IR[22:19];
    assign w_rc     = bus.IR[18:15];
    assign w_ra_hot = 16'h0001 << w_ra;
    assign w_rb_hot = 16'h0001 << w_rb;
    assign w_rc_hot = 16'h0001 << w_rc;

    // Opcode classification and ALU code; NOP and unknown opcodes fall through as no class
    always_comb begin
        w_binary   = 1'b0;
        w_unary    = 1'b0;
        w_halt     = 1'b0;
        w_alu_code = '0;
        case (w_opcode)
            OP_ADD:  begin w_binary = 1'b1; w_alu_code = ALU_ADD; end
            OP_SUB:  begin w_binary = 1'b1; w_alu_code = ALU_SUB; end
            OP_AND:  begin w_binary = 1'b1; w_alu_code = ALU_AND; end
            OP_OR:   begin w_binary = 1'b1; w_alu_code = ALU_OR;  end
            OP_NEG:  begin w_unary  = 1'b1; w_alu_code = ALU_NEG; end
            OP_NOT:  begin w_unary  = 1'b1; w_alu_code = ALU_NOT; end
            OP_HALT: w_halt = 1'b1;
            default: ;
        endcase
    end

    // Destination of any edge that would start a new fetch; stop takes priority over fetch
    always_comb begin
        if (bus.stop) begin
            w_fetch_next = ST_HALT;
        end else begin
`ifdef CTRL_STEP_EN
            w_fetch_next = ST_WAIT;
`else
            w_fetch_next = ST_T0;
`endif
        end
    end

    // T-state sequencer; clear aborts any instruction asynchronously
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= ST_RST;
        end else begin
            case (r_state)
                ST_RST:  r_state <= w_fetch_next;
                ST_T0:   r_state <= ST_T1;
                ST_T1:   r_state <= ST_T2;
                ST_T2:   r_state <= ST_T3;
                ST_T3: begin
                    if (w_halt)                  r_state <= ST_HALT;
                    else if (w_binary || w_unary) r_state <= ST_T4;
                    else                         r_state <= w_fetch_next;
                end
                ST_T4: begin
                    if (w_binary) r_state <= ST_T5;
                    else          r_state <= w_fetch_next;
                end
                ST_T5:   r_state <= w_fetch_next;
                ST_HALT: r_state <= ST_HALT;
`ifdef CTRL_STEP_EN
                ST_WAIT: if (bus.step) r_state <= ST_T0;
`endif
                default: r_state <= ST_RST;
            endcase
        end
    end

    // Strobe decode from the current state and the IR fields
    always_comb begin
        bus.Rin     = '0;
        bus.Rout    = '0;
        bus.PCin    = 1'b0;
        bus.PCout   = 1'b0;
        bus.IncPC   = 1'b0;
        bus.MARin   = 1'b0;
        bus.MDRin   = 1'b0;
        bus.MDRout  = 1'b0;
        bus.Read    = 1'b0;
        bus.IRin    = 1'b0;
        bus.Yin     = 1'b0;
        bus.Zlowin  = 1'b0;
        bus.Zlowout = 1'b0;
        bus.ALUop   = '0;
        bus.run     = (r_state != ST_RST) && (r_state != ST_HALT);
        case (r_state)
            ST_T0: begin
                bus.PCout  = 1'b1;
                bus.MARin  = 1'b1;
                bus.IncPC  = 1'b1;
                bus.Zlowin = 1'b1;
            end
            ST_T1: begin
                bus.Zlowout = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
            end
            ST_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            ST_T3: begin
                if (w_binary) begin
                    bus.Rout = w_rb_hot;
                    bus.Yin  = 1'b1;
                end else if (w_unary) begin
                    bus.Rout   = w_rb_hot;
                    bus.Zlowin = 1'b1;
                    bus.ALUop  = w_alu_code;
                end
            end
            ST_T4: begin
                if (w_binary) begin
                    bus.Rout   = w_rc_hot;
                    bus.Zlowin = 1'b1;
                    bus.ALUop  = w_alu_code;
                end else if (w_unary) begin
                    bus.Zlowout = 1'b1;
                    bus.Rin     = w_ra_hot;
                end
            end
            ST_T5: begin
                bus.Zlowout = 1'b1;
                bus.Rin     = w_ra_hot;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: directed checks of fetch, unary, binary, NOP/illegal,
// stop, HALT and asynchronous clear for ctrl_sequencer (default build).
module tb_ctrl_sequencer;

    logic clock;
    logic clear;
    int   n_cmp;
    int   n_err;

    ctrl_sequencer_if bus ();

    ctrl_sequencer dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus.master)
    );

    // Observed vector: {Rin, Rout, 11 flags, ALUop, run}
    localparam logic [10:0] F_PCIN    = 11'h400;
    localparam logic [10:0] F_PCOUT   = 11'h200;
    localparam logic [10:0] F_INCPC   = 11'h100;
    localparam logic [10:0] F_MARIN   = 11'h080;
    localparam logic [10:0] F_MDRIN   = 11'h040;
    localparam logic [10:0] F_MDROUT  = 11'h020;
    localparam logic [10:0] F_READ    = 11'h010;
    localparam logic [10:0] F_IRIN    = 11'h008;
    localparam logic [10:0] F_YIN     = 11'h004;
    localparam logic [10:0] F_ZLOWIN  = 11'h002;
    localparam logic [10:0] F_ZLOWOUT = 11'h001;

    localparam logic [47:0] V_ZERO = 48'h0;
    localparam logic [47:0] V_RUN  = 48'h1;
    localparam logic [47:0] V_T0 = {16'h0, 16'h0, F_PCOUT | F_MARIN | F_INCPC | F_ZLOWIN, 4'd0, 1'b1};
    localparam logic [47:0] V_T1 = {16'h0, 16'h0, F_ZLOWOUT | F_PCIN | F_READ | F_MDRIN, 4'd0, 1'b1};
    localparam logic [47:0] V_T2 = {16'h0, 16'h0, F_MDROUT | F_IRIN, 4'd0, 1'b1};

    logic [47:0] w_obs;
    assign w_obs = {bus.Rin, bus.Rout, bus.PCin, bus.PCout, bus.IncPC, bus.MARin,
                    bus.MDRin, bus.MDRout, bus.Read, bus.IRin, bus.Yin,
                    bus.Zlowin, bus.Zlowout, bus.ALUop, bus.run};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

`ifdef CTRL_STEP_EN
    initial bus.step = 1'b1;
`endif

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_cmp++;
            if (w_obs !== V_ZERO) begin
                n_err++;
                $display("FAIL reset cyc%0d got %h exp %h", i, w_obs, V_ZERO);
            end
        end
        clear = 1'b1;
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge clock);
        clear = 1'b0;
        #1;
        n_cmp++;
        if (w_obs !== V_ZERO) begin
            n_err++;
            $display("FAIL %s_pulse got %h exp %h", tag, w_obs, V_ZERO);
        end
        @(negedge clock);
        clear = 1'b1;
    endtask

    task automatic test_not();
        logic [47:0] exp [5];
        exp = '{V_T0, V_T1, V_T2,
                {16'h0000, 16'h0080, F_ZLOWIN, 4'd2, 1'b1},
                {16'h0010, 16'h0000, F_ZLOWOUT, 4'd0, 1'b1}};
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            n_cmp++;
            if (w_obs !== exp[i]) begin
                n_err++;
                $display("FAIL not cyc%0d got %h exp %h", i, w_obs, exp[i]);
            end
            if (i == 2) bus.IR = 32'h92380000;
        end
    endtask

    task automatic test_add();
        logic [47:0] exp [6];
        exp = '{V_T0, V_T1, V_T2,
                {16'h0000, 16'h0020, F_YIN, 4'd0, 1'b1},
                {16'h0000, 16'h0040, F_ZLOWIN, 4'd0, 1'b1},
                {16'h0004, 16'h0000, F_ZLOWOUT, 4'd0, 1'b1}};
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            n_cmp++;
            if (w_obs !== exp[i]) begin
                n_err++;
                $display("FAIL add cyc%0d got %h exp %h", i, w_obs, exp[i]);
            end
            if (i == 2) bus.IR = 32'h192B0000;
        end
    endtask

    task automatic test_illegal();
        logic [47:0] exp [5];
        exp = '{V_T0, V_T1, V_T2, V_RUN, V_T0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            n_cmp++;
            if (w_obs !== exp[i]) begin
                n_err++;
                $display("FAIL illegal cyc%0d got %h exp %h", i, w_obs, exp[i]);
            end
            if (i == 2) bus.IR = 32'h00000000;
            if (i == 3) bus.IR = 32'hD0000000;
        end
        // Second pass: same fetch via opcode 11010 (NOP)
        exp = '{V_T1, V_T2, V_RUN, V_ZERO, V_ZERO};
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_cmp++;
            if (w_obs !== exp[i]) begin
                n_err++;
                $display("FAIL nop cyc%0d got %h exp %h", i, w_obs, exp[i]);
            end
        end
    endtask

    task automatic test_stop();
        logic [47:0] exp [5];
        exp = '{V_T0, V_T1, V_T2,
                {16'h0000, 16'h0080, F_ZLOWIN, 4'd2, 1'b1},
                {16'h0010, 16'h0000, F_ZLOWOUT, 4'd0, 1'b1}};
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            n_cmp++;
            if (w_obs !== exp[i]) begin
                n_err++;
                $display("FAIL stop_not cyc%0d got %h exp %h", i, w_obs, exp[i]);
            end
            if (i == 0) bus.stop = 1'b1;
            if (i == 2) bus.IR = 32'h92380000;
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            n_cmp++;
            if (w_obs !== V_ZERO) begin
                n_err++;
                $display("FAIL stop_halt cyc%0d got %h exp %h", i, w_obs, V_ZERO);
            end
            if (i == 2) bus.stop = 1'b0;
        end
    endtask

    task automatic test_halt();
        logic [47:0] exp [4];
        reset_pulse("halt");
        exp = '{V_T0, V_T1, V_T2, V_RUN};
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            n_cmp++;
            if (w_obs !== exp[i]) begin
                n_err++;
                $display("FAIL halt_fetch cyc%0d got %h exp %h", i, w_obs, exp[i]);
            end
            if (i == 2) bus.IR = 32'hD8000000;
        end
        for (int i = 0; i < 22; i++) begin
            @(negedge clock);
            n_cmp++;
            if (w_obs !== V_ZERO) begin
                n_err++;
                $display("FAIL halt_hold cyc%0d got %h exp %h", i, w_obs, V_ZERO);
            end
        end
    endtask

    task automatic test_clear_mid();
        logic [47:0] exp [5];
        reset_pulse("mid");
        exp = '{V_T0, V_T1, V_T2,
                {16'h0000, 16'h0020, F_YIN, 4'd0, 1'b1},
                {16'h0000, 16'h0040, F_ZLOWIN, 4'd0, 1'b1}};
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            n_cmp++;
            if (w_obs !== exp[i]) begin
                n_err++;
                $display("FAIL mid_add cyc%0d got %h exp %h", i, w_obs, exp[i]);
            end
            if (i == 2) bus.IR = 32'h192B0000;
        end
        #2 clear = 1'b0;
        #1;
        n_cmp++;
        if (w_obs !== V_ZERO) begin
            n_err++;
            $display("FAIL mid_async got %h exp %h", w_obs, V_ZERO);
        end
        @(negedge clock);
        n_cmp++;
        if (w_obs !== V_ZERO) begin
            n_err++;
            $display("FAIL mid_held got %h exp %h", w_obs, V_ZERO);
        end
        clear = 1'b1;
        exp = '{V_T0, V_T1, V_T2, V_RUN, V_T0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            n_cmp++;
            if (w_obs !== exp[i]) begin
                n_err++;
                $display("FAIL mid_resume cyc%0d got %h exp %h", i, w_obs, exp[i]);
            end
            if (i == 2) bus.IR = 32'h00000000;
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        clear    = 1'b0;
        bus.IR   = 32'h0;
        bus.stop = 1'b0;
        test_reset();
        test_not();
        test_add();
        test_illegal();
        test_stop();
        test_halt();
        test_clear_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Hardwired control unit that sits directly upstream of the datapath.
- Steps the T-state sequence for fetch and for register-register ALU instructions.
- Decodes the IR value returned by the datapath and drives every datapath control strobe: register one-hots, PC/MAR/MDR/IR/Y/Z enables, Read and ALUop.
- Moore-style: every output is decoded combinationally from the state register and the IR fields.

Parameters:
ALU_ADD, 4'd0, ALUop code for add
ALU_SUB, 4'd1, ALUop code for sub
ALU_NOT, 4'd2, ALUop code for not
ALU_AND, 4'd3, ALUop code for and
ALU_OR, 4'd4, ALUop code for or
ALU_NEG, 4'd5, ALUop code for neg

Ports:
clock  in  1  system clock, rising edge
clear  in  1  asynchronous, active-low reset (0 = reset)
IR  in  32  instruction register contents from datapath
stop  in  1  halt request
Rin  out  16  one-hot general-register load enables
Rout  out  16  one-hot general-register bus drives
PCin, PCout, IncPC  out  1 each  PC controls
MARin  out  1  MAR load
MDRin, MDRout, Read  out  1 each  MDR load, MDR drive, memory read select
IRin  out  1  IR load
Yin  out  1  Y load
Zlowin, Zlowout  out  1 each  Z low load / drive
ALUop  out  4  ALU operation select
run  out  1  1 while executing, 0 when halted or in reset

Behaviour:
- IR fields:
  - opcode = IR[31:27], Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15].
- Opcode map:
  - ADD 00011, SUB 00100, AND 00101, OR 00110: binary class.
  - NEG 10001, NOT 10010: unary class.
  - NOP 11010.
  - HALT 11011.
  - Any other opcode executes as NOP.
- States: RST, T0, T1, T2, T3, T4, T5, HALT.
- Reset:
  - clear=0 forces state RST immediately, with no clock edge needed.
  - All outputs are 0 in RST, run=0.
  - First rising edge after clear returns to 1: RST -> T0.
- Output decode per state (everything not listed is 0):
  - T0: PCout, MARin, IncPC, Zlowin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin. IR is loaded at the end of T2 and is valid from T3 onward.
  - Binary class:
    - T3: Rout[Rb], Yin.
    - T4: Rout[Rc], Zlowin, ALUop = code.
    - T5: Zlowout, Rin[Ra].
  - Unary class:
    - T3: Rout[Rb], Zlowin, ALUop = code.
    - T4: Zlowout, Rin[Ra].
  - ALUop is 0 in every state where it is not listed above.
- Transitions:
  - T0 -> T1 -> T2 -> T3.
  - T3: binary -> T4; unary -> T4; NOP/illegal -> T0; HALT -> HALT.
  - T4: binary -> T5; unary -> T0.
  - T5 -> T0.
- Cycle counts including fetch: binary = 6 cycles, unary = 5 cycles, NOP = 4 cycles.
- Stop:
  - Sampled on every edge whose next state would be T0.
  - If stop=1, go to HALT instead; the current instruction completes first.
- HALT:
  - All strobes are 0, run=0.
  - HALT is left only by reset.
- run = 1 in T0..T5.
- Register strobes:
  - Rin and Rout are always one-hot or zero; both are never nonzero together.
  - Ra = Rb is legal: Rout[Rb] and Rin[Ra] fall in different states.
- Reset mid-instruction: the instruction is aborted. No partial strobe persists past the asynchronous assertion of clear.

Optional Feature:
- Macro: CTRL_STEP_EN.
- Defined:
  - Adds input port step (1 bit) and state WAIT.
  - Every edge that would enter T0, including RST -> T0, enters WAIT instead.
  - WAIT drives all strobes 0, run=1.
  - WAIT -> T0 on an edge with step=1; otherwise WAIT holds.
  - stop is checked before WAIT.
- Undefined: no step port, no WAIT state; behaviour exactly as above.

Test Plan:
- Reset, then IR=0x92380000 (not R4,R7) loaded at T2 -> T3: Rout=0x0080, ALUop=2, Zlowin=1; T4: Zlowout=1, Rin=0x0010; next cycle T0 (PCout=1, MARin=1, IncPC=1).
- IR=0x192B0000 (add R2,R5,R6) -> T3: Rout=0x0020, Yin=1; T4: Rout=0x0040, ALUop=0, Zlowin=1; T5: Rin=0x0004, Zlowout=1; six cycles total.
- IR=0xD8000000 (HALT) -> after T3, state HALT, run=0, all strobes 0 for 20+ cycles; clear pulse low then high -> T0 on the next edge.
- stop=1 held during a not instruction -> T4 completes with Rin=0x0010, then HALT with run=0; no T0 strobes appear.
- clear driven low mid-T4 of the add -> outputs 0 within the same cycle with no clock edge; release -> T0 on the next edge, full fetch resumes.
- IR=0x00000000 (illegal) -> T3 all strobes 0, next state T0; with CTRL_STEP_EN, step=0 holds WAIT with strobes 0, and step=1 for one cycle -> T0.
